cifra_simon128: RTL

Simon 128/128 encryption datapath, directly downstream of the key schedule. It accepts one 128-bit plaintext block and then consumes one 64-bit round key per round from the key-schedule stream. It iterates the Feistel round 68 times and presents the 128-bit ciphertext on a ready/valid output. One round per accepted round key; one block in flight at a time.

---
 rtl/simon_pkg.sv | 28 ++
 rtl/cifra_simon128_if.sv | 35 +++
 rtl/simon_f.sv | 19 +
 rtl/cifra_simon128.sv | 86 ++++++++
 4 files changed

// File: rtl/simon_pkg.sv
//==============================================================================
// Module      : simon_pkg
// Description : Shared types, sizes and rotate helper for the Simon 128/128 cores
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package simon_pkg;

  localparam int ROUNDS = 68;
  localparam int WORD   = 64;
  localparam int RND_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } simon_state_t;

  typedef logic [WORD-1:0] simon_word_t;

  function automatic simon_word_t rol(input simon_word_t v, input int unsigned s);
    return (v << s) | (v >> (WORD - s));
  endfunction

endpackage

`default_nettype wire

// File: rtl/cifra_simon128_if.sv
//==============================================================================
// Module      : cifra_simon128_if
// Description : Plaintext / round-key / ciphertext handshake bundle
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface cifra_simon128_if;
  import simon_pkg::*;

  logic             pt_valid_i;
  logic             pt_ready_o;
  logic [127:0]     pt_i;
  logic             rk_valid_i;
  logic             rk_ready_o;
  simon_word_t      rk_i;
  logic             ct_valid_o;
  logic             ct_ready_i;
  logic [127:0]     ct_o;
  logic             busy_o;
  logic [RND_W-1:0] round_o;

  modport slave (
    input  pt_valid_i, pt_i, rk_valid_i, rk_i, ct_ready_i,
    output pt_ready_o, rk_ready_o, ct_valid_o, ct_o, busy_o, round_o
  );

  modport master (
    output pt_valid_i, pt_i, rk_valid_i, rk_i, ct_ready_i,
    input  pt_ready_o, rk_ready_o, ct_valid_o, ct_o, busy_o, round_o
  );

endinterface

`default_nettype wire

// File: rtl/simon_f.sv
//==============================================================================
// Module      : simon_f
// Description : Combinational Simon round function f(x) = (x<<<1 & x<<<8) ^ x<<<2
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module simon_f
  import simon_pkg::*;
(
  input  simon_word_t x_i,
  output simon_word_t f_o
);

  assign f_o = (rol(x_i, 1) & rol(x_i, 8)) ^ rol(x_i, 2);

endmodule

`default_nettype wire

// File: rtl/cifra_simon128.sv
//==============================================================================
// Module      : cifra_simon128
// Description : Iterative Simon 128/128 encryption, one round per accepted key
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cifra_simon128
  import simon_pkg::*;
(
  input  wire              clk,
  input  wire              rst,
  cifra_simon128_if.slave  bus
);

  simon_state_t     state_q, state_d;
  simon_word_t      x_q, x_d;
  simon_word_t      y_q, y_d;
  logic [RND_W-1:0] round_q, round_d;
  simon_word_t      f_x;

  simon_f u_f (
    .x_i (x_q),
    .f_o (f_x)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (bus.pt_valid_i) begin
          x_d     = bus.pt_i[127:64];
          y_d     = bus.pt_i[63:0];
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.rk_valid_i) begin
          x_d = y_q ^ f_x ^ bus.rk_i;
          y_d = x_q;
          // The counter parks on the last index so round_o never exceeds ROUNDS-1.
          if (round_q == RND_W'(ROUNDS - 1)) begin
            state_d = DONE;
          end else begin
            round_d = round_q + RND_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.ct_ready_i) begin
          round_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pt_ready_o = (state_q == IDLE);
  assign bus.rk_ready_o = (state_q == RUN);
  assign bus.ct_valid_o = (state_q == DONE);
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.round_o    = round_q;
  assign bus.ct_o       = (state_q == DONE) ? {x_q, y_q} : 128'd0;

endmodule

`default_nettype wire
